pcs_dec_lite: RTL
=================

# pcs_dec_lite

Receive-side 64b/66b PCS decoder: the counterpart of the lite transmit encoder. Accepts descrambled 66-bit blocks (2-bit sync header plus 64-bit payload) and classifies each block. Tracks frame state with a clause-49-style receive FSM and emits registered MAC-side data, byte keep and control strobes. Supported block types are 0x1e idle, 0x78 start-on-lane-0 and terminate 0x87..0xff; all others are errors.

## Interface
- DATA_W, 64, payload width; only 64 supported
- KEEP_W, DATA_W/8, byte-enable width
- BLOCK_TYPE_W, 8, block type field width
- ERR_CNT_W, 8, error counter width
- clk  in  1  data clock
- nreset  in  1  reset; synchronous, active-low
- valid_i  in  1  block present this cycle
- sync_head_i  in  2  2'b01 data, 2'b10 control, others invalid
- data_i  in  DATA_W  block payload, byte 0 = block type when control
- valid_o  out  1  output block valid
- ctrl_v_o  out  1  block was a control block
- idle_v_o, start_v_o, term_v_o, err_v_o  out  1 each  decoded block kind; at most one set
- data_o  out  DATA_W  payload, byte 0 forced 8'h00 for control blocks
- keep_o  out  KEEP_W  valid bytes of data_o
- err_cnt_o  out  ERR_CNT_W  error block count

## Operation
- Classify (combinational, per valid_i block):
  - DATA: sync 01.
  - IDLE: sync 10, type 0x1e, all eight 7-bit control codes = 7'h00.
  - START: sync 10, type 0x78.
  - TERM_k (k=0..7): sync 10, type 0x87,0x99,0xaa,0xb4,0xcc,0xd2,0xe1,0xff.
  - INVALID: anything else, incl. sync 00/11, 0x1e with nonzero codes, 0x2d/0x33/0x4b/0x55/0x66.
  - Trailing control bytes of TERM blocks are not checked.
- Output mapping:
  - DATA: data_o=data_i, keep_o=8'hff.
  - START: data_o={data_i[63:8],8'h00}, keep_o=8'hfe.
  - TERM_k: data_o={data_i[63:8],8'h00}, keep_o=((1<<k)-1)<<1; k=0 gives 8'h00.
  - IDLE: data_o=0, keep_o=0.
  - Error: data_o=0, keep_o=0, err_v_o=1, other strobes 0.
- FSM states RX_INIT, RX_C, RX_D, RX_E; advances only on valid_i:
  - RX_INIT, RX_C, RX_E: IDLE->RX_C; START->RX_D; DATA/TERM/INVALID->RX_E (error).
  - RX_D: DATA->RX_D; TERM->RX_C; IDLE/START/INVALID->RX_E (error).
- An error is output for every block that causes a transition into RX_E or that arrives in RX_E without being IDLE or START.
- ctrl_v_o = sync_head_i[1] of the accepted block, even when erroring.

## Timing
- Latency 1 cycle: block on valid_i at edge n appears on outputs after edge n+1.
- valid_i=0: valid_o=0 next cycle, FSM holds, data/keep/strobes zeroed.
- No backpressure; one block per cycle sustained.
- Reset (nreset=0 at edge): state RX_INIT; valid_o, ctrl_v_o, all strobes, data_o, keep_o, err_cnt_o = 0. Reset wins over a simultaneous valid_i, and a frame in flight is discarded.
- First accepted block after reset is judged in RX_INIT.

## Configuration
- PCS_DEC_ERR_CNT_EN defined: err_cnt_o increments by 1 on each cycle err_v_o is asserted. It saturates at all-ones and clears only on reset.
- Undefined: counter not built, err_cnt_o tied 0.

## Structure
- Shared package pcs_pkg:
  - BLOCK_TYPE_* constants, shared with the encoder.
  - CTRL_IDLE.
  - RX state enum.
  - Sync header constants SYNC_DATA=2'b01, SYNC_CTRL=2'b10.
- One sub-module, pcs_dec_block_class: combinational classifier from sync_head_i/data_i to block kind, term index k and invalid flag.
- FSM, output register and counter live in pcs_dec_lite.

## Test plan
- Reset then IDLE (sync 10, data 64'h1e) -> next cycle valid_o=1, idle_v_o=1, ctrl_v_o=1, keep_o=8'h00, data_o=0.
- START (type 0x78, data_i=64'h0706050403020178), DATA (sync 01, 64'hffeeddccbbaa9988), TERM_3 (0xb4), IDLE -> strobes start/-/term/idle; keep 8'hfe, 8'hff, 8'h0e, 8'h00; no err_v_o.
- DATA right after reset -> err_v_o=1, keep_o=0. Following IDLE returns to RX_C with no error.
- In RX_D, send START -> err_v_o=1; next DATA still err_v_o=1 (stays RX_E); then START recovers, start_v_o=1.
- Sync header 2'b00 mid-frame, then type 0x1e with control code 7'h01 -> err_v_o=1 on both. With PCS_DEC_ERR_CNT_EN, err_cnt_o advances by 2.
- Assert nreset=0 mid-frame with valid_i=1 -> outputs all 0 next cycle. Following TERM_0 -> err_v_o=1 (RX_INIT). Drive 300 errors -> err_cnt_o saturates at 8'hff.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync headers, block types, receive FSM states.
// Used by both the lite encoder and decoder.
package pcs_pkg;

  localparam int DATA_W       = 64;
  localparam int KEEP_W       = DATA_W / 8;
  localparam int BLOCK_TYPE_W = 8;
  localparam int ERR_CNT_W    = 8;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_IDLE  = 8'h1e;
  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_START = 8'h78;
  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_TERM0 = 8'h87;
  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_TERM1 = 8'h99;
  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_TERM2 = 8'haa;
  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_TERM3 = 8'hb4;
  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_TERM4 = 8'hcc;
  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_TERM5 = 8'hd2;
  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_TERM6 = 8'he1;
  localparam logic [BLOCK_TYPE_W-1:0] BLOCK_TYPE_TERM7 = 8'hff;

  localparam logic [6:0] CTRL_IDLE = 7'h00;

  typedef enum logic [1:0] {
    RX_INIT = 2'd0,
    RX_C    = 2'd1,
    RX_D    = 2'd2,
    RX_E    = 2'd3
  } rx_state_e;

  // TERM_k carries k data bytes in lanes 1..k.
  function automatic logic [KEEP_W-1:0] term_keep(input logic [2:0] k);
    logic [KEEP_W-1:0] mask;
    mask = (8'h01 << k) - 8'h01;
    return {mask[KEEP_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/pcs_dec_block_class.sv
// Combinational 64b/66b block classifier: sync header and block type to
// block kind, terminate lane index and invalid flag.
module pcs_dec_block_class
  import pcs_pkg::*;
(
  input  logic [1:0]  sync_head_i,
  input  logic [63:0] data_i,
  output logic        is_data,
  output logic        is_idle,
  output logic        is_start,
  output logic        is_term,
  output logic        invalid,
  output logic [2:0]  term_k
);

  logic [BLOCK_TYPE_W-1:0] btype;

  assign btype = data_i[BLOCK_TYPE_W-1:0];

  always_comb begin
    is_data  = 1'b0;
    is_idle  = 1'b0;
    is_start = 1'b0;
    is_term  = 1'b0;
    term_k   = 3'd0;
    if (sync_head_i == SYNC_DATA) begin
      is_data = 1'b1;
    end else if (sync_head_i == SYNC_CTRL) begin
      case (btype)
        BLOCK_TYPE_IDLE:  is_idle  = (data_i[63:8] == {8{CTRL_IDLE}});
        BLOCK_TYPE_START: is_start = 1'b1;
        BLOCK_TYPE_TERM0: begin is_term = 1'b1; term_k = 3'd0; end
        BLOCK_TYPE_TERM1: begin is_term = 1'b1; term_k = 3'd1; end
        BLOCK_TYPE_TERM2: begin is_term = 1'b1; term_k = 3'd2; end
        BLOCK_TYPE_TERM3: begin is_term = 1'b1; term_k = 3'd3; end
        BLOCK_TYPE_TERM4: begin is_term = 1'b1; term_k = 3'd4; end
        BLOCK_TYPE_TERM5: begin is_term = 1'b1; term_k = 3'd5; end
        BLOCK_TYPE_TERM6: begin is_term = 1'b1; term_k = 3'd6; end
        BLOCK_TYPE_TERM7: begin is_term = 1'b1; term_k = 3'd7; end
        default: ;
      endcase
    end
  end

  assign invalid = ~(is_data | is_idle | is_start | is_term);

endmodule

// File: rtl/pcs_dec_lite.sv
// Receive-side 64b/66b PCS decoder with a clause-49-style frame FSM.
// Optional saturating error counter: define PCS_DEC_ERR_CNT_EN.
//
// state   | meaning
// RX_INIT | after reset, no block judged yet
// RX_C    | between frames, idles accepted
// RX_D    | inside a frame, data/terminate expected
// RX_E    | error seen, waiting for idle or start
module pcs_dec_lite
  import pcs_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int KEEP_W       = DATA_W / 8,
  parameter int BLOCK_TYPE_W = 8,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 valid_i,
  input  logic [1:0]           sync_head_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic                 valid_o,
  output logic                 ctrl_v_o,
  output logic                 idle_v_o,
  output logic                 start_v_o,
  output logic                 term_v_o,
  output logic                 err_v_o,
  output logic [DATA_W-1:0]    data_o,
  output logic [KEEP_W-1:0]    keep_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  rx_state_e state_q, state_d;

  logic       is_data, is_idle, is_start, is_term, invalid;
  logic [2:0] term_k;
  logic       blk_err;

  logic              ctrl_d, idle_d, start_d, term_d, err_d;
  logic [DATA_W-1:0] data_d;
  logic [KEEP_W-1:0] keep_d;

  pcs_dec_block_class u_class (
    .sync_head_i (sync_head_i),
    .data_i      (data_i),
    .is_data     (is_data),
    .is_idle     (is_idle),
    .is_start    (is_start),
    .is_term     (is_term),
    .invalid     (invalid),
    .term_k      (term_k)
  );

  always_comb begin
    state_d = state_q;
    blk_err = 1'b0;
    if (valid_i) begin
      case (state_q)
        RX_D: begin
          if (is_data) begin
            state_d = RX_D;
          end else if (is_term) begin
            state_d = RX_C;
          end else begin
            state_d = RX_E;
            blk_err = 1'b1;
          end
        end
        default: begin
          if (is_idle) begin
            state_d = RX_C;
          end else if (is_start) begin
            state_d = RX_D;
          end else begin
            state_d = RX_E;
            blk_err = 1'b1;
          end
        end
      endcase
    end
  end

  // Lane 0 of a control block is the type byte, never MAC data.
  always_comb begin
    ctrl_d  = valid_i & sync_head_i[1];
    idle_d  = 1'b0;
    start_d = 1'b0;
    term_d  = 1'b0;
    err_d   = 1'b0;
    data_d  = '0;
    keep_d  = '0;
    if (valid_i) begin
      if (blk_err || invalid) begin
        err_d = 1'b1;
      end else if (is_data) begin
        data_d = data_i;
        keep_d = '1;
      end else if (is_idle) begin
        idle_d = 1'b1;
      end else if (is_start) begin
        start_d = 1'b1;
        data_d  = {data_i[DATA_W-1:8], 8'h00};
        keep_d  = 8'hfe;
      end else begin
        term_d = 1'b1;
        data_d = {data_i[DATA_W-1:8], 8'h00};
        keep_d = term_keep(term_k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= RX_INIT;
      valid_o   <= 1'b0;
      ctrl_v_o  <= 1'b0;
      idle_v_o  <= 1'b0;
      start_v_o <= 1'b0;
      term_v_o  <= 1'b0;
      err_v_o   <= 1'b0;
      data_o    <= '0;
      keep_o    <= '0;
    end else begin
      state_q   <= state_d;
      valid_o   <= valid_i;
      ctrl_v_o  <= ctrl_d;
      idle_v_o  <= idle_d;
      start_v_o <= start_d;
      term_v_o  <= term_d;
      err_v_o   <= err_d;
      data_o    <= data_d;
      keep_o    <= keep_d;
    end
  end

`ifdef PCS_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule
